// File: rtl/netlist_toggle_monitor_pkg.sv
// netlist_toggle_monitor_pkg: shared state encoding, defaults and popcount width helper
package tm_power_pkg;
  typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} state_t;
  localparam int DEF_WIDTH = 62;
  localparam int DEF_WINDOW = 10;
  function automatic int pop_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/netlist_toggle_monitor_if.sv
// netlist_toggle_monitor_if: sample stream in, measurement result out
interface netlist_toggle_monitor_if
  import tm_power_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
);
  localparam int POP_W = pop_w(WIDTH);
  logic start;
  logic abort;
  logic sample_valid;
  logic [WIDTH-1:0] sample_data;
  logic busy;
  logic result_valid;
  logic result_ready;
  logic [ACC_W-1:0] total_toggles;
  logic [POP_W-1:0] max_toggles;
  logic [CNT_W-1:0] sample_count;
  logic acc_overflow;
  modport master (
    output start, abort, sample_valid, sample_data, result_ready,
    input busy, result_valid, total_toggles, max_toggles, sample_count, acc_overflow
  );
  modport slave (
    input start, abort, sample_valid, sample_data, result_ready,
    output busy, result_valid, total_toggles, max_toggles, sample_count, acc_overflow
  );
endinterface

// File: rtl/netlist_toggle_monitor_popcount.sv
// tm_popcount: combinational population count of a WIDTH-bit vector
module tm_popcount
  import tm_power_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int POP_W = pop_w(WIDTH)
) (
  input  logic [WIDTH-1:0] d,
  output logic [POP_W-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + POP_W'(d[i]);
  end
endmodule

// File: rtl/netlist_toggle_monitor.sv
// netlist_toggle_monitor: windowed toggle activity measurement with valid/ready result
module netlist_toggle_monitor
  import tm_power_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WINDOW = DEF_WINDOW,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16,
  localparam int POP_W = pop_w(WIDTH)
) (
  input logic clk,
  input logic rst,
  netlist_toggle_monitor_if.slave m
);
  state_t state;
  logic [WIDTH-1:0] prev, xor_q;
  logic xv_q, busy, rv, ovf;
  logic [ACC_W-1:0] total;
  logic [POP_W-1:0] mx, pop;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W:0] sum;
  tm_popcount #(.WIDTH(WIDTH)) u_pop (.d(xor_q), .cnt(pop));
  assign sum = {1'b0, total} + (ACC_W + 1)'(pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev <= '0;
      xor_q <= '0;
      xv_q <= 1'b0;
      total <= '0;
      mx <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      busy <= 1'b0;
      rv <= 1'b0;
    end else if (m.abort) begin
      state <= IDLE;
      xv_q <= 1'b0;
      busy <= 1'b0;
      rv <= 1'b0;
    end else begin
      xv_q <= 1'b0;
      // second pipeline stage: fold the previous transition into the results
      if (xv_q) begin
        total <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        ovf <= ovf | sum[ACC_W];
        mx <= (pop > mx) ? pop : mx;
      end
      case (state)
        IDLE: if (m.start) begin
          state <= ARM;
          busy <= 1'b1;
          total <= '0;
          mx <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end
        ARM: if (m.sample_valid) begin
          prev <= m.sample_data;
          cnt <= CNT_W'(1);
          state <= (WINDOW == 1) ? DRAIN : RUN;
        end
        RUN: if (m.sample_valid) begin
          xor_q <= m.sample_data ^ prev;
          xv_q <= 1'b1;
          prev <= m.sample_data;
          cnt <= cnt + CNT_W'(1);
          state <= (cnt == CNT_W'(WINDOW - 1)) ? DRAIN : RUN;
        end
        DRAIN: begin
          state <= DONE;
          busy <= 1'b0;
          rv <= 1'b1;
        end
        DONE: if (m.result_ready) begin
          rv <= 1'b0;
          state <= m.start ? ARM : IDLE;
          busy <= m.start;
          if (m.start) begin
            total <= '0;
            mx <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign m.busy = busy;
  assign m.result_valid = rv;
  assign m.total_toggles = total;
  assign m.max_toggles = mx;
  assign m.sample_count = cnt;
  assign m.acc_overflow = ovf;
endmodule
